// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared state encoding, default windows and sizing helper for the APB bridge
package apb_bridge_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;

    localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h1000_0000;
    localparam logic [31:0] DEFAULT_SLAVE_SPAN = 32'h0000_1000;

    // A single slave still needs a one-bit index register.
    function automatic int index_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - combinational window decode of a byte address into hit, slave index and one-hot select
module apb_addr_decoder
    import apb_bridge_pkg::*;
#(
    parameter int          NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter logic [31:0] SLAVE_SPAN = DEFAULT_SLAVE_SPAN,
    parameter int          IDX_W      = index_width(NUM_SLAVES)
) (
    input  logic [31:0]           addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      index,
    output logic [NUM_SLAVES-1:0] onehot
);

    localparam int          SPAN_SHIFT = $clog2(SLAVE_SPAN);
    // Upper bound computed in 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(NUM_SLAVES) * {1'b0, SLAVE_SPAN};

    logic [31:0] offset;
    logic [31:0] slot;

    always_comb begin
        offset = addr - BASE_ADDR;
        slot   = offset >> SPAN_SHIFT;
        hit    = (addr >= BASE_ADDR) && ({1'b0, addr} < LIMIT);
        index  = slot[IDX_W-1:0];
        onehot = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            onehot[s] = hit && (slot == 32'(s));
        end
    end

endmodule

// File: rtl/apb_bridge_multi.sv
// rtl/apb_bridge_multi.sv - core memory port to multi-slave APB4 bridge with strobes, slave error and wait-state timeout
module apb_bridge_multi
    import apb_bridge_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          DATA_W         = 32,
    parameter int          PADDR_W        = 12,
    parameter logic [31:0] BASE_ADDR      = DEFAULT_BASE_ADDR,
    parameter logic [31:0] SLAVE_SPAN     = DEFAULT_SLAVE_SPAN,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_write,
    input  logic                         mem_read,
    input  logic [31:0]                  mem_addr,
    input  logic [DATA_W-1:0]            mem_write_data,
    input  logic [DATA_W/8-1:0]          mem_byte_en,
    output logic [DATA_W-1:0]            mem_read_data,
    output logic                         mem_ready,
    output logic                         mem_resp_valid,
    output logic                         mem_error,
    output logic                         PCLK,
    output logic                         PRESETn,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [PADDR_W-1:0]           PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W/8-1:0]          PSTRB,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int IDX_W = index_width(NUM_SLAVES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [IDX_W-1:0]        sel_idx;
    logic [CNT_W-1:0]        wait_cnt;

    logic                    dec_hit;
    logic [IDX_W-1:0]        dec_index;
    logic [NUM_SLAVES-1:0]   dec_onehot;

    logic                    slave_ready;
    logic                    slave_err;
    logic [DATA_W-1:0]       slave_rdata;

    assign PCLK    = clk;
    assign PRESETn = ~rst;

    apb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .BASE_ADDR  (BASE_ADDR),
        .SLAVE_SPAN (SLAVE_SPAN),
        .IDX_W      (IDX_W)
    ) u_decoder (
        .addr   (mem_addr),
        .hit    (dec_hit),
        .index  (dec_index),
        .onehot (dec_onehot)
    );

    // Only the selected slave's handshake is observed; other slaves may toggle freely.
    assign slave_ready = PREADY[sel_idx];
    assign slave_err   = PSLVERR[sel_idx];
    assign slave_rdata = PRDATA[32'(sel_idx) * DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            sel_idx        <= '0;
            wait_cnt       <= '0;
            PSEL           <= '0;
            PENABLE        <= 1'b0;
            PWRITE         <= 1'b0;
            PADDR          <= '0;
            PWDATA         <= '0;
            PSTRB          <= '0;
            mem_read_data  <= '0;
            mem_resp_valid <= 1'b0;
            mem_error      <= 1'b0;
            mem_ready      <= 1'b1;
        end else begin
            mem_resp_valid <= 1'b0;
            mem_error      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // The response-cycle guard keeps the just-completed request from re-issuing.
                    if (dec_hit && (mem_read || mem_write) && !mem_resp_valid) begin
                        sel_idx   <= dec_index;
                        PSEL      <= dec_onehot;
                        PWRITE    <= mem_write;
                        PADDR     <= mem_addr[PADDR_W-1:0];
                        PWDATA    <= mem_write_data;
                        PSTRB     <= mem_write ? mem_byte_en : '0;
                        mem_ready <= 1'b0;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (slave_ready) begin
                        mem_read_data  <= PWRITE ? '0 : slave_rdata;
                        mem_error      <= slave_err;
                        mem_resp_valid <= 1'b1;
                        PSEL           <= '0;
                        PENABLE        <= 1'b0;
                        mem_ready      <= 1'b1;
                        state          <= ST_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        mem_read_data  <= '0;
                        mem_error      <= 1'b1;
                        mem_resp_valid <= 1'b1;
                        PSEL           <= '0;
                        PENABLE        <= 1'b0;
                        mem_ready      <= 1'b1;
                        state          <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_bridge_multi.sv
// tb/tb_apb_bridge_multi.sv - table-driven and randomized self-checking bench for apb_bridge_multi
module tb_apb_bridge_multi;

    localparam int          NS   = 4;
    localparam int          TMO  = 8;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          SPAN = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_write, mem_read;
    logic [31:0]  mem_addr, mem_write_data;
    logic [3:0]   mem_byte_en;
    logic [31:0]  mem_read_data;
    logic         mem_ready, mem_resp_valid, mem_error;
    logic         PCLK, PRESETn;
    logic [NS-1:0] PSEL;
    logic         PENABLE, PWRITE;
    logic [11:0]  PADDR;
    logic [31:0]  PWDATA;
    logic [3:0]   PSTRB;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0] PREADY, PSLVERR;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          wait_n;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  exp_psel;
        int          exp_resp;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    apb_bridge_multi #(
        .NUM_SLAVES     (NS),
        .DATA_W         (32),
        .PADDR_W        (12),
        .BASE_ADDR      (BASE),
        .SLAVE_SPAN     (32'(SPAN)),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_byte_en    (mem_byte_en),
        .mem_read_data  (mem_read_data),
        .mem_ready      (mem_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_error      (mem_error),
        .PCLK           (PCLK),
        .PRESETn        (PRESETn),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PADDR          (PADDR),
        .PWDATA         (PWDATA),
        .PSTRB          (PSTRB),
        .PRDATA         (PRDATA),
        .PREADY         (PREADY),
        .PSLVERR        (PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: window arithmetic plus the latency rule 2 + ACCESS cycles.
    function automatic vec_t predict(input vec_t v);
        longint off;
        int     access_n;
        logic   timed_out;
        off       = longint'({32'h0, v.addr}) - longint'({32'h0, BASE});
        timed_out = (v.wait_n >= TMO);
        access_n  = timed_out ? TMO : v.wait_n + 1;
        v.exp_psel  = (off >= 0 && off < NS * SPAN) ? 4'(1 << (off / SPAN)) : 4'b0;
        v.exp_resp  = (v.exp_psel == 4'b0) ? 0 : 2 + access_n;
        v.exp_err   = timed_out ? 1'b1 : v.err;
        v.exp_rdata = (timed_out || v.wr) ? 32'h0 : v.rdata;
        return v;
    endfunction

    task automatic randomize_slaves();
        PRDATA  = {$urandom, $urandom, $urandom, $urandom};
        PREADY  = 4'($urandom);
        PSLVERR = 4'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int  idx = 0;
        logic busy;
        @(negedge clk);
        mem_write      = v.wr;
        mem_read       = v.rd;
        mem_addr       = v.addr;
        mem_write_data = v.wdata;
        mem_byte_en    = v.be;
        randomize_slaves();
        if (v.exp_psel == 4'b0) begin
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                check("miss_psel", PSEL, 0);
                check("miss_ready", mem_ready, 1);
                check("miss_resp", mem_resp_valid, 0);
                randomize_slaves();
            end
            mem_write = 1'b0;
            mem_read  = 1'b0;
            return;
        end
        for (int s = 0; s < NS; s++) if (v.exp_psel[s]) idx = s;
        for (int c = 1; c <= v.exp_resp + 1; c++) begin
            @(negedge clk);
            busy = (c < v.exp_resp);
            check("psel", PSEL, busy ? v.exp_psel : 4'b0);
            check("penable", PENABLE, (c >= 2) && busy);
            check("mem_ready", mem_ready, !busy);
            check("resp_valid", mem_resp_valid, c == v.exp_resp);
            if (busy) begin
                check("paddr", PADDR, v.addr[11:0]);
                check("pwrite", PWRITE, v.wr);
                check("pstrb", PSTRB, v.wr ? v.be : 4'b0);
                check("pwdata", PWDATA, v.wdata);
            end
            if (c == v.exp_resp) begin
                check("mem_error", mem_error, v.exp_err);
                check("read_data", mem_read_data, v.exp_rdata);
                mem_write = 1'b0;
                mem_read  = 1'b0;
            end
            if (c == v.exp_resp + 1) begin
                check("error_cleared", mem_error, 0);
                check("read_data_held", mem_read_data, v.exp_rdata);
            end
            randomize_slaves();
            PRDATA[idx*32 +: 32] = v.rdata;
            if (busy && c >= 2) begin
                PREADY[idx] = (c - 2 == v.wait_n);
                if (c - 2 == v.wait_n) PSLVERR[idx] = v.err;
            end
        end
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h1000_1004, 32'hDEAD_BEEF, 4'b0011, 0,   32'h0,         1'b0, 4'b0010, 3,  1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b1, 32'h1000_3010, 32'h0,         4'b1111, 3,   32'h1234_5678, 1'b0, 4'b1000, 6,  1'b0, 32'h1234_5678};
        tbl[2] = '{1'b0, 1'b1, 32'h1000_2020, 32'h0,         4'b0000, 2,   32'hA5A5_0001, 1'b1, 4'b0100, 5,  1'b1, 32'hA5A5_0001};
        tbl[3] = '{1'b0, 1'b1, 32'h1000_0008, 32'h0,         4'b0000, 100, 32'hCAFE_F00D, 1'b0, 4'b0001, 10, 1'b1, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 32'h1000_4000, 32'h0,         4'b0000, 0,   32'h0,         1'b0, 4'b0000, 0,  1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'h0FFF_FFFC, 32'h5555_AAAA, 4'b1111, 0,   32'h0,         1'b0, 4'b0000, 0,  1'b0, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 32'h1000_0010, 32'h1122_3344, 4'b1111, 1,   32'h0000_0055, 1'b0, 4'b0001, 4,  1'b0, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'h1000_3FFC, 32'h7777_8888, 4'b1000, 0,   32'h0,         1'b1, 4'b1000, 3,  1'b1, 32'h0};

        rst = 1'b1;
        mem_write = 1'b0; mem_read = 1'b0; mem_addr = '0;
        mem_write_data = '0; mem_byte_en = '0;
        PRDATA = '0; PREADY = '0; PSLVERR = '0;
        repeat (2) @(negedge clk);
        check("rst_presetn", PRESETn, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_pstrb", PSTRB, 0);
        check("rst_read_data", mem_read_data, 0);
        check("rst_resp", mem_resp_valid, 0);
        check("rst_error", mem_error, 0);
        check("rst_ready", mem_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        check("presetn_released", PRESETn, 1);

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            int sel_kind;
            int m;
            sel_kind = $urandom_range(0, 9);
            m = $urandom_range(1, 3);
            rv.wr = m[0];
            rv.rd = m[1];
            if (sel_kind == 0)      rv.addr = BASE - 32'(4 * $urandom_range(1, 64));
            else if (sel_kind == 1) rv.addr = BASE + 32'(NS * SPAN) + 32'(4 * $urandom_range(0, 64));
            else                    rv.addr = BASE + 32'(4 * $urandom_range(0, NS * SPAN / 4 - 1));
            rv.wdata  = $urandom;
            rv.be     = 4'($urandom);
            rv.wait_n = $urandom_range(0, 9);
            rv.rdata  = $urandom;
            rv.err    = 1'($urandom);
            run_vec(predict(rv));
        end

        // Reset while the selected slave stalls in ACCESS.
        @(negedge clk);
        PREADY = '0; PSLVERR = '0;
        mem_read = 1'b1; mem_addr = 32'h1000_1000;
        repeat (4) @(negedge clk);
        check("pre_rst_penable", PENABLE, 1);
        check("pre_rst_psel", PSEL, 4'b0010);
        rst = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        check("abort_psel", PSEL, 0);
        check("abort_penable", PENABLE, 0);
        check("abort_ready", mem_ready, 1);
        check("abort_resp", mem_resp_valid, 0);
        check("abort_presetn", PRESETn, 0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_abort_resp", mem_resp_valid, 0);
            check("post_abort_psel", PSEL, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
